// File: rtl/pong_game_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_sequencer_if
// Description : Step request/acknowledge bus between the Pong game-flow
//               sequencer (master) and the ball/paddle/collision datapath
//               (slave). It also carries the ball recentre pulse and the
//               serve direction.
// Revision    : 1.0 - initial release
// ============================================================================
interface pong_game_sequencer_if;
  logic       step_req;
  logic [1:0] step_id;
  logic       step_done;
  logic       miss_left;
  logic       miss_right;
  logic       ball_reset;
  logic       serve_dir;

  modport master (
    output step_req, step_id, ball_reset, serve_dir,
    input  step_done, miss_left, miss_right
  );

  modport slave (
    input  step_req, step_id, ball_reset, serve_dir,
    output step_done, miss_left, miss_right
  );
endinterface
`default_nettype wire

// File: rtl/pong_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_sequencer
// Description : Pong match controller. It runs the IDLE/SERVE/PLAY/OVER flow
//               and divides frame pulses into game ticks. On each tick it
//               drives the datapath through an ordered request/acknowledge
//               step sequence. It also keeps the scores and picks the serve
//               direction.
//               Optional feature macro: PONG_PAUSE_EN (pause button support).
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_sequencer #(
  parameter int FRAME_DIV   = 2,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  start_btn,
  input  logic                  pause_btn,
  pong_game_sequencer_if.master bus,
  output logic [1:0]            state,
  output logic [3:0]            score_p,
  output logic [3:0]            score_o,
  output logic                  overrun
);

  localparam logic [5:0] DIV_LAST   = 6'(FRAME_DIV - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_DELAY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t     cur, nxt;
  logic       start_q;
  logic       tick;
  logic [5:0] frame_cnt;
  logic [7:0] serve_cnt;
  logic       full;          // in-flight sequence runs all three steps
  logic       entry;         // first cycle spent in SERVE
  logic       paused;

  logic active, start_rise, ack, last_ack, tick_ok, enter_serve;
  logic launch, match_start, point_p, point_o;

  assign active      = (cur == SERVE) || (cur == PLAY);
  assign start_rise  = start_btn && !start_q;
  assign ack         = bus.step_done && bus.step_req;
  assign last_ack    = ack && (!full || bus.step_id == 2'd2);
  assign tick_ok     = tick && active && !paused;
  assign enter_serve = (nxt == SERVE) && (cur != SERVE);
  assign state       = cur;

`ifdef PONG_PAUSE_EN
  logic pause_q;

  // Pause flag: toggled by a button edge during a match, cleared when the match stops or restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_q <= 1'b0;
      paused  <= 1'b0;
    end else begin
      pause_q <= pause_btn;
      if (match_start || nxt == IDLE || nxt == OVER)
        paused <= 1'b0;
      else if (pause_btn && !pause_q && active)
        paused <= ~paused;
    end
  end
`else
  wire unused_pause_btn = pause_btn;
  assign paused = 1'b0;
`endif

  // Button edge reference copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= start_btn;
  end

  // Frame divider: one-cycle tick every FRAME_DIV frames, only while a match is running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 6'd0;
      tick      <= 1'b0;
    end else if (!active) begin
      frame_cnt <= 6'd0;
      tick      <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (frame_start && !paused) begin
        if (frame_cnt == DIV_LAST) begin
          frame_cnt <= 6'd0;
          tick      <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 6'd1;
        end
      end
    end
  end

  // Match state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= IDLE;
    else        cur <= nxt;
  end

  // Next-state and control strobes; launches only happen with the bus idle
  always_comb begin
    nxt         = cur;
    launch      = 1'b0;
    match_start = 1'b0;
    point_p     = 1'b0;
    point_o     = 1'b0;
    case (cur)
      IDLE, OVER: begin
        if (start_rise) begin
          match_start = 1'b1;
          nxt         = SERVE;
        end
      end
      SERVE: begin
        if (tick_ok && !bus.step_req) begin
          launch = 1'b1;
          if (serve_cnt <= 8'd1) nxt = PLAY;
        end
      end
      PLAY: begin
        if (tick_ok && !bus.step_req) launch = 1'b1;
        if (ack && full && bus.step_id == 2'd2) begin
          if (bus.miss_left && !bus.miss_right) begin
            point_p = 1'b1;
            nxt     = (score_p + 4'd1 == WIN) ? OVER : SERVE;
          end else if (bus.miss_right && !bus.miss_left) begin
            point_o = 1'b1;
            nxt     = (score_o + 4'd1 == WIN) ? OVER : SERVE;
          end else if (bus.miss_left && bus.miss_right) begin
            nxt = SERVE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Step sequencer: request held until acknowledged, id advances per acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.step_req <= 1'b0;
      bus.step_id  <= 2'd0;
      full         <= 1'b0;
    end else if (launch) begin
      bus.step_req <= 1'b1;
      bus.step_id  <= 2'd0;
      full         <= (cur == PLAY);
    end else if (ack) begin
      if (last_ack) begin
        bus.step_req <= 1'b0;
        bus.step_id  <= 2'd0;
      end else begin
        bus.step_id  <= bus.step_id + 2'd1;
      end
    end
  end

  // Scores, serve direction and the sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_p       <= 4'd0;
      score_o       <= 4'd0;
      bus.serve_dir <= 1'b1;
      overrun       <= 1'b0;
    end else if (match_start) begin
      score_p       <= 4'd0;
      score_o       <= 4'd0;
      bus.serve_dir <= 1'b1;
      overrun       <= 1'b0;
    end else begin
      if (tick_ok && bus.step_req) overrun <= 1'b1;
      if (point_p) begin
        if (score_p < WIN) score_p <= score_p + 4'd1;
        bus.serve_dir <= 1'b0;
      end
      if (point_o) begin
        if (score_o < WIN) score_o <= score_o + 4'd1;
        bus.serve_dir <= 1'b1;
      end
    end
  end

  // Serve countdown and the ball recentre pulse one cycle after entering SERVE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      serve_cnt      <= 8'd0;
      entry          <= 1'b0;
      bus.ball_reset <= 1'b0;
    end else begin
      entry          <= enter_serve;
      bus.ball_reset <= entry;
      if (enter_serve)
        serve_cnt <= SERVE_LOAD;
      else if (launch && cur == SERVE && serve_cnt != 8'd0)
        serve_cnt <= serve_cnt - 8'd1;
    end
  end

endmodule
`default_nettype wire
